// File: rtl/digit_ctrl_pkg.sv
// =====================================================================
// digit_ctrl_pkg : shared types and constants for the digit controller
// rev 1.0
// =====================================================================
`default_nettype none

package digit_ctrl_pkg;

  typedef enum logic [0:0] {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } mode_t;

  // Digit 3 is thousands, digit 0 is units.
  typedef logic [3:0][3:0] bcd4_t;

  localparam int KEY_INC = 0;
  localparam int KEY_DEC = 1;
  localparam int KEY_CLR = 2;
  localparam int KEY_RUN = 3;

  localparam int FIELD_W = 128;
  localparam int FIELD_H = 32;

endpackage

`default_nettype wire

// File: rtl/bcd_counter4.sv
// =====================================================================
// bcd_counter4 : 4-digit wrapping BCD up/down counter with clear
// rev 1.0
// =====================================================================
`default_nettype none

module bcd_counter4
  import digit_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  inc,
  input  logic  dec,
  input  logic  clr,
  output bcd4_t value
);

  function automatic bcd4_t bcd_inc(input bcd4_t v);
    bcd4_t r;
    logic  carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = r[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic bcd4_t bcd_dec(input bcd4_t v);
    bcd4_t r;
    logic  borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (r[i] == 4'd0) begin
          r[i] = 4'd9;
        end else begin
          r[i]   = r[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  bcd4_t value_nxt;

  // Simultaneous inc and dec cancel; clear overrides both.
  always_comb begin
    value_nxt = value;
    if (clr) begin
      value_nxt = '0;
    end else if (inc && !dec) begin
      value_nxt = bcd_inc(value);
    end else if (dec && !inc) begin
      value_nxt = bcd_dec(value);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else begin
      value <= value_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/digit_frame_ctrl.sv
// =====================================================================
// digit_frame_ctrl : frame-synchronous key handling, run mode and render
// rev 1.0
// =====================================================================
`default_nettype none

module digit_frame_ctrl
  import digit_ctrl_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 60,
  parameter int KEY_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keys,
  input  logic       vsync,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  output logic [3:0] digit,
  output logic [2:0] xofs,
  output logic [2:0] yofs,
  output logic       digit_en,
  output logic       running
);

  localparam int              CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic [KEY_SYNC_STAGES-1:0][3:0] key_sync;
  logic [3:0]       key_prev;
  logic [3:0]       key_rise;
  logic             vsync_sync;
  logic             vsync_prev;
  logic             frame_tick;
  logic [3:0]       pending;
  logic [CNT_W-1:0] frame_cnt;
  mode_t            state;
  mode_t            state_nxt;
  logic             key_change;
  logic             auto_step;
  logic             ctr_inc;
  logic             ctr_dec;
  logic             ctr_clr;
  bcd4_t            value;
  logic             in_field;
  logic [1:0]       digit_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_sync <= '0;
      key_prev <= '0;
    end else begin
      key_sync[0] <= keys;
      for (int i = 1; i < KEY_SYNC_STAGES; i++) begin
        key_sync[i] <= key_sync[i-1];
      end
      key_prev <= key_sync[KEY_SYNC_STAGES-1];
    end
  end

  assign key_rise = key_sync[KEY_SYNC_STAGES-1] & ~key_prev;

  // History resets high so that release with vsync idle produces no tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_sync <= 1'b1;
      vsync_prev <= 1'b1;
    end else begin
      vsync_sync <= vsync;
      vsync_prev <= vsync_sync;
    end
  end

  assign frame_tick = vsync_prev & ~vsync_sync;

  // An edge landing on the tick itself seeds the next frame's pending set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if (frame_tick) begin
      pending <= key_rise;
    end else begin
      pending <= pending | key_rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PAUSED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (frame_tick && pending[KEY_RUN]) begin
      state_nxt = (state == PAUSED) ? RUNNING : PAUSED;
    end
  end

  always_comb begin
    running = (state == RUNNING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (state != RUNNING || state_nxt != RUNNING) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
    end
  end

  assign key_change = pending[KEY_CLR] | (pending[KEY_INC] ^ pending[KEY_DEC]);
  assign auto_step  = (state == RUNNING) && (frame_cnt == CNT_LAST);

  assign ctr_clr = frame_tick & pending[KEY_CLR];
  assign ctr_dec = frame_tick & ~pending[KEY_CLR] & pending[KEY_DEC] & ~pending[KEY_INC];
  assign ctr_inc = frame_tick & ((~pending[KEY_CLR] & pending[KEY_INC] & ~pending[KEY_DEC])
                                 | (auto_step & ~key_change));

  bcd_counter4 u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (ctr_inc),
    .dec   (ctr_dec),
    .clr   (ctr_clr),
    .value (value)
  );

  assign in_field  = display_on && (hpos < 9'(FIELD_W)) && (vpos < 9'(FIELD_H));
  assign digit_sel = 2'd3 - hpos[6:5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit    <= '0;
      xofs     <= '0;
      yofs     <= '0;
      digit_en <= 1'b0;
    end else begin
      digit    <= in_field ? value[digit_sel] : 4'd0;
      xofs     <= hpos[4:2];
      yofs     <= vpos[4:2];
      digit_en <= in_field;
    end
  end

endmodule

`default_nettype wire
